// File: rtl/hd63701_intc_pkg.sv
// HD63701 interrupt controller shared definitions: vectors, FSM states,
// pending-bit layout. Optional: HD63701_EXTSYNC_EN (2-flop NMI/IRQ sync).
package hd63701_intc_pkg;

    localparam logic [7:0] VEC_NMI = 8'hFC;
    localparam logic [7:0] VEC_IRQ = 8'hF8;
    localparam logic [7:0] VEC_ICF = 8'hF6;
    localparam logic [7:0] VEC_OCF = 8'hF4;
    localparam logic [7:0] VEC_TOF = 8'hF2;
    localparam logic [7:0] VEC_SCI = 8'hF0;

    localparam int NSRC  = 6;
    localparam int P_NMI = 5;
    localparam int P_IRQ = 4;
    localparam int P_ICF = 3;
    localparam int P_OCF = 2;
    localparam int P_TOF = 1;
    localparam int P_SCI = 0;

`ifdef HD63701_EXTSYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 0;
`endif

    // Cycles after reset before the NMI history holds a real pin sample.
    localparam logic [1:0] ARM_CYC = 2'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic src_live(
        input logic [NSRC-1:0] pend,
        input logic [7:0]      vec
    );
        logic live;
        live = 1'b0;
        case (vec)
            VEC_NMI: live = pend[P_NMI];
            VEC_IRQ: live = pend[P_IRQ];
            VEC_ICF: live = pend[P_ICF];
            VEC_OCF: live = pend[P_OCF];
            VEC_TOF: live = pend[P_TOF];
            VEC_SCI: live = pend[P_SCI];
            default: live = 1'b0;
        endcase
        return live;
    endfunction

endpackage

// File: rtl/hd63701_intc_if.sv
// Pin/flag bundle between the CPU core, peripherals and the interrupt
// controller; master drives sources and ack, slave is the controller.
interface hd63701_intc_if;

    logic       NMI;
    logic       IRQ;
    logic       ICF;
    logic       OCF;
    logic       TOF;
    logic       SCI;
    logic       EICI;
    logic       EOCI;
    logic       ETOI;
    logic       inte;
    logic       ack;
    logic       irq_req;
    logic [7:0] irq_vec;
    logic       nmi_pend;
    logic       wake;

    modport master (
        output NMI, IRQ, ICF, OCF, TOF, SCI,
        output EICI, EOCI, ETOI, inte, ack,
        input  irq_req, irq_vec, nmi_pend, wake
    );

    modport slave (
        input  NMI, IRQ, ICF, OCF, TOF, SCI,
        input  EICI, EOCI, ETOI, inte, ack,
        output irq_req, irq_vec, nmi_pend, wake
    );

endinterface

// File: rtl/hd63701_intc_prio.sv
// Fixed-priority encoder: NMI > IRQ > ICF > OCF > TOF > SCI.
module hd63701_intc_prio
    import hd63701_intc_pkg::*;
(
    input  logic [NSRC-1:0] pend_i,
    output logic [7:0]      vec_o,
    output logic            valid_o
);

    always_comb begin
        vec_o   = 8'h00;
        valid_o = |pend_i;
        priority case (1'b1)
            pend_i[P_NMI]: vec_o = VEC_NMI;
            pend_i[P_IRQ]: vec_o = VEC_IRQ;
            pend_i[P_ICF]: vec_o = VEC_ICF;
            pend_i[P_OCF]: vec_o = VEC_OCF;
            pend_i[P_TOF]: vec_o = VEC_TOF;
            pend_i[P_SCI]: vec_o = VEC_SCI;
            default:       vec_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/hd63701_intc.sv
// HD63701 interrupt controller top: NMI edge latch, request FSM, wake.
// Optional: HD63701_EXTSYNC_EN adds 2-flop sync on the NMI/IRQ pins.
module hd63701_intc
    import hd63701_intc_pkg::*;
(
    input  logic           CLKp,
    input  logic           RSTn,
    hd63701_intc_if.slave  bus
);

    logic nmi_s;
    logic irq_s;

`ifdef HD63701_EXTSYNC_EN
    logic [1:0] nmi_sync_q;
    logic [1:0] irq_sync_q;

    always_ff @(posedge CLKp or negedge RSTn) begin
        if (!RSTn) begin
            nmi_sync_q <= 2'b00;
            irq_sync_q <= 2'b00;
        end else begin
            nmi_sync_q <= {nmi_sync_q[0], bus.NMI};
            irq_sync_q <= {irq_sync_q[0], bus.IRQ};
        end
    end

    assign nmi_s = nmi_sync_q[1];
    assign irq_s = irq_sync_q[1];
`else
    assign nmi_s = bus.NMI;
    assign irq_s = bus.IRQ;
`endif

    state_e          state_q, state_d;
    logic [7:0]      vec_q, vec_d;
    logic            nmi_q, nmi_d;
    logic            nmi_prev_q;
    logic [1:0]      arm_q, arm_d;
    logic            armed;
    logic            nmi_edge;
    logic            nmi_clr;
    logic [NSRC-1:0] pend;
    logic [7:0]      win_vec;
    logic            win_valid;

    // History is untrusted until it has seen a real sample after reset,
    // so a pin held high through reset release is not taken as an edge.
    assign armed    = (arm_q == ARM_CYC);
    assign arm_d    = armed ? arm_q : arm_q + 2'd1;
    assign nmi_edge = armed & nmi_s & ~nmi_prev_q;

    assign pend[P_NMI] = nmi_q | nmi_edge;
    assign pend[P_IRQ] = irq_s & bus.inte;
    assign pend[P_ICF] = bus.ICF & bus.EICI & bus.inte;
    assign pend[P_OCF] = bus.OCF & bus.EOCI & bus.inte;
    assign pend[P_TOF] = bus.TOF & bus.ETOI & bus.inte;
    assign pend[P_SCI] = bus.SCI & bus.inte;

    hd63701_intc_prio u_prio (
        .pend_i  (pend),
        .vec_o   (win_vec),
        .valid_o (win_valid)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        nmi_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_REQ;
                    vec_d   = win_vec;
                end
            end
            ST_REQ: begin
                if (bus.ack) begin
                    state_d = ST_HOLD;
                    nmi_clr = (vec_q == VEC_NMI);
                end else if (vec_q != VEC_NMI &&
                             !src_live(pend, vec_q)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A fresh edge beats a same-cycle clear.
        nmi_d = nmi_edge | (nmi_q & ~nmi_clr);
    end

    always_ff @(posedge CLKp or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            vec_q      <= 8'h00;
            nmi_q      <= 1'b0;
            nmi_prev_q <= 1'b0;
            arm_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            nmi_q      <= nmi_d;
            nmi_prev_q <= nmi_s;
            arm_q      <= arm_d;
        end
    end

    assign bus.irq_req  = (state_q == ST_REQ);
    assign bus.irq_vec  = vec_q;
    assign bus.nmi_pend = nmi_q;
    assign bus.wake     = |pend;

endmodule

// File: tb/tb_hd63701_intc.sv
// Scoreboard bench for hd63701_intc; also builds with
// HD63701_EXTSYNC_EN (pin latency becomes 3 cycles).
module tb_hd63701_intc;

    logic CLKp = 1'b0;
    logic RSTn = 1'b0;

    hd63701_intc_if bus ();

    hd63701_intc dut (
        .CLKp (CLKp),
        .RSTn (RSTn),
        .bus  (bus.slave)
    );

    always #5 CLKp = ~CLKp;

`ifdef HD63701_EXTSYNC_EN
    localparam int L = 3;
`else
    localparam int L = 1;
`endif

    typedef struct {
        int         cyc;
        string      tag;
        logic       req;
        logic [7:0] vec;
        logic       np;
    } exp_t;

    exp_t sb[$];
    int   cnt    = 0;
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] want
    );
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    task automatic exp_at(
        input int         off,
        input string      tag,
        input logic       req,
        input logic [7:0] vec,
        input logic       np
    );
        exp_t e;
        e.cyc = cnt + off;
        e.tag = tag;
        e.req = req;
        e.vec = vec;
        e.np  = np;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLKp);
    endtask

    always @(posedge CLKp) begin : mon
        exp_t e;
        cnt++;
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cnt) begin
            e = sb.pop_front();
            chk({e.tag, ".req"}, 32'(bus.irq_req), 32'(e.req));
            chk({e.tag, ".vec"}, 32'(bus.irq_vec), 32'(e.vec));
            chk({e.tag, ".np"}, 32'(bus.nmi_pend), 32'(e.np));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.NMI  = 1'b0;
        bus.IRQ  = 1'b0;
        bus.ICF  = 1'b0;
        bus.OCF  = 1'b0;
        bus.TOF  = 1'b0;
        bus.SCI  = 1'b0;
        bus.EICI = 1'b0;
        bus.EOCI = 1'b0;
        bus.ETOI = 1'b0;
        bus.inte = 1'b0;
        bus.ack  = 1'b0;
        tick(2);
        chk("rst.req", 32'(bus.irq_req), 32'd0);
        chk("rst.vec", 32'(bus.irq_vec), 32'd0);
        chk("rst.np", 32'(bus.nmi_pend), 32'd0);
        RSTn = 1'b1;
        tick(4);

        // OCF request, ack, hold, no re-request
        bus.OCF  = 1'b1;
        bus.EOCI = 1'b1;
        bus.inte = 1'b1;
        #1 chk("t1.wake", 32'(bus.wake), 32'd1);
        exp_at(1, "t1.req", 1'b1, 8'hF4, 1'b0);
        tick(1);
        bus.ack = 1'b1;
        exp_at(1, "t1.hold", 1'b0, 8'hF4, 1'b0);
        tick(1);
        bus.ack = 1'b0;
        bus.OCF = 1'b0;
        exp_at(1, "t1.idle", 1'b0, 8'hF4, 1'b0);
        exp_at(2, "t1.quiet", 1'b0, 8'hF4, 1'b0);
        tick(3);

        // enable gating of wake
        bus.OCF  = 1'b1;
        bus.inte = 1'b0;
        #1 chk("w.inte0", 32'(bus.wake), 32'd0);
        exp_at(1, "w.noreq", 1'b0, 8'hF4, 1'b0);
        tick(1);
        bus.inte = 1'b1;
        bus.EOCI = 1'b0;
        #1 chk("w.eoci0", 32'(bus.wake), 32'd0);
        exp_at(1, "w.noreq2", 1'b0, 8'hF4, 1'b0);
        tick(1);
        bus.OCF = 1'b0;
        tick(1);

        // IRQ+TOF+SCI together, serviced in priority order
        bus.IRQ = 1'b1;
        tick(L - 1);
        bus.TOF  = 1'b1;
        bus.ETOI = 1'b1;
        bus.SCI  = 1'b1;
        exp_at(1, "t2.irq", 1'b1, 8'hF8, 1'b0);
        tick(1);
        bus.ack = 1'b1;
        bus.IRQ = 1'b0;
        exp_at(1, "t2.hold1", 1'b0, 8'hF8, 1'b0);
        tick(1);
        bus.ack = 1'b0;
        exp_at(1, "t2.idle1", 1'b0, 8'hF8, 1'b0);
        tick(1);
        exp_at(1, "t2.tof", 1'b1, 8'hF2, 1'b0);
        tick(1);
        bus.ack = 1'b1;
        bus.TOF = 1'b0;
        exp_at(1, "t2.hold2", 1'b0, 8'hF2, 1'b0);
        tick(1);
        bus.ack = 1'b0;
        exp_at(1, "t2.idle2", 1'b0, 8'hF2, 1'b0);
        tick(1);
        exp_at(1, "t2.sci", 1'b1, 8'hF0, 1'b0);
        tick(1);
        bus.ack = 1'b1;
        bus.SCI = 1'b0;
        exp_at(1, "t2.hold3", 1'b0, 8'hF0, 1'b0);
        tick(1);
        bus.ack = 1'b0;
        exp_at(1, "t2.done", 1'b0, 8'hF0, 1'b0);
        tick(L + 2);

        // NMI with interrupts masked
        bus.inte = 1'b0;
        tick(1);
        bus.NMI = 1'b1;
        exp_at(L, "t3.nmi", 1'b1, 8'hFC, 1'b1);
        tick(L);
        #1 chk("t3.wake", 32'(bus.wake), 32'd1);
        bus.ack = 1'b1;
        exp_at(1, "t3.ack", 1'b0, 8'hFC, 1'b0);
        tick(1);
        bus.ack = 1'b0;
        exp_at(1, "t3.idle", 1'b0, 8'hFC, 1'b0);
        exp_at(2, "t3.held1", 1'b0, 8'hFC, 1'b0);
        exp_at(3, "t3.held2", 1'b0, 8'hFC, 1'b0);
        tick(4);
        bus.NMI = 1'b0;
        bus.IRQ = 1'b1;
        tick(L + 1);
        #1 chk("t3.wake_irq_masked", 32'(bus.wake), 32'd0);
        bus.IRQ = 1'b0;
        tick(L + 1);

        // IRQ pulse with no ack: withdrawal
        bus.inte = 1'b1;
        bus.IRQ  = 1'b1;
        exp_at(L, "t4.rise", 1'b1, 8'hF8, 1'b0);
        exp_at(L + 1, "t4.stay", 1'b1, 8'hF8, 1'b0);
        exp_at(L + 2, "t4.wd", 1'b0, 8'hF8, 1'b0);
        exp_at(L + 3, "t4.quiet", 1'b0, 8'hF8, 1'b0);
        tick(2);
        bus.IRQ = 1'b0;
        tick(L + 3);

        // NMI arriving while ICF is requested
        bus.ICF  = 1'b1;
        bus.EICI = 1'b1;
        exp_at(1, "t5.icf", 1'b1, 8'hF6, 1'b0);
        tick(1);
        bus.NMI = 1'b1;
        exp_at(L, "t5.nopreempt", 1'b1, 8'hF6, 1'b1);
        tick(L);
        bus.ack = 1'b1;
        exp_at(1, "t5.hold", 1'b0, 8'hF6, 1'b1);
        tick(1);
        bus.ack = 1'b0;
        bus.ICF = 1'b0;
        exp_at(1, "t5.idle", 1'b0, 8'hF6, 1'b1);
        tick(1);
        exp_at(1, "t5.nmi", 1'b1, 8'hFC, 1'b1);
        tick(1);
        bus.ack = 1'b1;
        exp_at(1, "t5.nmihold", 1'b0, 8'hFC, 1'b0);
        tick(1);
        bus.ack = 1'b0;
        exp_at(1, "t5.end", 1'b0, 8'hFC, 1'b0);
        tick(2);
        bus.NMI = 1'b0;
        tick(L + 2);

        // reset in the middle of an NMI request
        bus.NMI = 1'b1;
        exp_at(L, "t6.req", 1'b1, 8'hFC, 1'b1);
        tick(L);
        #2 RSTn = 1'b0;
        #1;
        chk("t6.rst.req", 32'(bus.irq_req), 32'd0);
        chk("t6.rst.vec", 32'(bus.irq_vec), 32'd0);
        chk("t6.rst.np", 32'(bus.nmi_pend), 32'd0);
        tick(2);
        RSTn = 1'b1;
        for (int k = 1; k <= 6; k++)
            exp_at(k, "t6.noedge", 1'b0, 8'h00, 1'b0);
        tick(7);
        bus.NMI = 1'b0;
        tick(2);

        chk("sb.drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
